switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
// - Conditions the raw board slide switches before they reach the core.
// - Per bit: synchroniser chain, then a debounce state machine. Produces glitch-free switch levels.
// - Sits directly upstream of the program counter, which uses sw8 for its hold/condition test.
// - The remaining clean bits feed the datapath input operand.
// PARAMETERS
// - N_SW            10  number of switch bits; must be >= 9 because sw8 = bit 8
// - SYNC_STAGES     2   flip-flops in each synchroniser chain; must be >= 2
// - DEBOUNCE_CYCLES 16  cycles a new level must persist before acceptance; must be >= 2
// PORTS
// - Clock     in   1      rising-edge system clock
// - nReset    in   1      reset, asynchronous, active-low
// - sw_raw    in   N_SW   asynchronous switch inputs
// - sw_clean  out  N_SW   debounced switch levels
// - sw8       out  1      equals sw_clean[8]; drives the program counter
// - settled   out  1      high when every bit is in STABLE
// - sw_rise   out  N_SW   one-cycle pulse when a sw_clean bit goes 0->1 (SW_EDGE_EN)
// - sw_fall   out  N_SW   one-cycle pulse when a sw_clean bit goes 1->0 (SW_EDGE_EN)
// BEHAVIOUR
// - Reset values (async, nReset low):
//   - all sync flops = 0, sw_clean = 0, sw8 = 0
//   - counters = 0, every bit in STABLE
//   - settled = 1, sw_rise = 0, sw_fall = 0
// - Synchroniser:
//   - sw_raw[i] shifts through SYNC_STAGES flops.
//   - s[i] is the last stage.
//   - No combinational path exists from sw_raw to any output.
// - Counter:
//   - One per bit, width $clog2(DEBOUNCE_CYCLES).
//   - Counts in CHECK; never wraps.
// - Per-bit FSM, two states:
//   - STABLE, s[i]==sw_clean[i]: stay; cnt = 0.
//   - STABLE, s[i]!=sw_clean[i]: go to CHECK; cnt = 1.
//   - CHECK, s[i]==sw_clean[i] (glitch): go to STABLE; cnt = 0; sw_clean unchanged.
//   - CHECK, s[i]!=sw_clean[i], cnt < DEBOUNCE_CYCLES-1: cnt++.
//   - CHECK, s[i]!=sw_clean[i], cnt == DEBOUNCE_CYCLES-1: sw_clean[i] <= s[i]; go to STABLE; cnt = 0.
// - Latency:
//   - A clean raw step is sampled at edge 1.
//   - sw_clean changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
// - Glitch rejection:
//   - A synchronised pulse shorter than DEBOUNCE_CYCLES cycles never reaches sw_clean.
//   - Any return to the accepted level restarts the full count.
// - Independence: bits run fully independently; simultaneous changes on several bits each take their own path.
// - Outputs are registered:
//   - sw_clean and sw8 are flops.
//   - settled is the registered AND of all STABLE flags.
//   - settled is low during any cycle in which a bit is in CHECK.
// - Reset mid-count: returns to the reset state immediately; a partial count is discarded.
// - Static inputs after reset: a switch held at 1 through reset is accepted SYNC_STAGES+DEBOUNCE_CYCLES edges after release.
// CONFIGURATION
// - Macro: SW_EDGE_EN
// - Defined:
//   - sw_rise[i] / sw_fall[i] are registered.
//   - Each is high for exactly the one cycle after the edge where sw_clean[i] updates 1 / 0.
// - Undefined:
//   - sw_rise and sw_fall are tied to 0.
//   - No edge flops are built.
//   - All other behaviour is identical.
// TESTING
// Bench parameters: N_SW=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// - Reset, sw_raw=0 -> sw_clean=0, sw8=0, settled=1, sw_rise=sw_fall=0.
// - sw_raw[8] 0->1 before edge 1, held -> settled=0 after edge 3; sw8=1 and settled=1 after edge 6, not after edge 5.
// - sw_raw[8] high for 3 cycles, then low -> sw8 stays 0 throughout; settled returns to 1.
// - sw_raw=10'h3FF held, then nReset pulsed low at the 2nd CHECK cycle -> all outputs 0 immediately; sw_clean=10'h3FF 6 edges after release.
// - SW_EDGE_EN, sw_raw[0] 0->1 then 1->0 after 10 cycles -> one sw_rise[0] pulse, one sw_fall[0] pulse, each 1 cycle wide.
// - Bits 0 and 9 change 2 cycles apart -> each updates exactly 6 edges after its own change; no cross-coupling.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions the raw board slide switches before they reach
// the core. Each bit passes through a SYNC_STAGES flop synchroniser and then a
// two-state debounce FSM with a saturating persistence counter.
// sw_clean[8] is mirrored on sw8 for the program counter's hold/condition test.
//
// Optional feature: define SW_EDGE_EN to build registered one-cycle sw_rise /
// sw_fall pulses. With SW_EDGE_EN undefined both are tied to 0 and no edge
// flops exist.
//
// Per-bit FSM states:
//   state  | meaning
//   STABLE | synchronised level matches sw_clean, counter held at 0
//   CHECK  | synchronised level differs, counting how long it persists

module switch_debouncer #(
  parameter int N_SW            = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic            sw8,
  output logic            settled,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

  logic [N_SW-1:0] sync_q [SYNC_STAGES];
  logic [N_SW-1:0] s;

  state_t          state_q   [N_SW];
  state_t          state_nxt [N_SW];
  logic [CW-1:0]   cnt_q     [N_SW];
  logic [CW-1:0]   cnt_nxt   [N_SW];
  logic [N_SW-1:0] clean_nxt;
  logic            settled_nxt;

  // Shift raw switch levels through the synchroniser chain.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state decode for every bit; settled looks at the next state so it
  // drops in the same cycle a bit enters CHECK.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    clean_nxt   = sw_clean;
    settled_nxt = 1'b1;
    for (int i = 0; i < N_SW; i++) begin
      case (state_q[i])
        STABLE: begin
          if (s[i] != sw_clean[i]) begin
            state_nxt[i] = CHECK;
            cnt_nxt[i]   = CW'(1);
          end else begin
            cnt_nxt[i] = '0;
          end
        end
        CHECK: begin
          if (s[i] == sw_clean[i]) begin
            // Glitch: the accepted level came back, so the count restarts.
            state_nxt[i] = STABLE;
            cnt_nxt[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            clean_nxt[i] = s[i];
            state_nxt[i] = STABLE;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_nxt[i] = STABLE;
          cnt_nxt[i]   = '0;
        end
      endcase
      settled_nxt = settled_nxt & (state_nxt[i] == STABLE);
    end
  end

  // Debounce FSM state, counters and registered level outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      sw_clean <= '0;
      sw8      <= 1'b0;
      settled  <= 1'b1;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= state_nxt[i];
        cnt_q[i]   <= cnt_nxt[i];
      end
      sw_clean <= clean_nxt;
      sw8      <= clean_nxt[8];
      settled  <= settled_nxt;
    end
  end

`ifdef SW_EDGE_EN
  // One-cycle edge pulses, aligned with the sw_clean update.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= clean_nxt & ~sw_clean;
      sw_fall <= ~clean_nxt & sw_clean;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (N_SW=10, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Stimulus pushes cycle-tagged expected output snapshots
// and expected sw_clean changes; a monitor pops and compares them.

module tb_switch_debouncer;

  localparam int N = 10;
`ifdef SW_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         nReset;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_clean;
  logic         sw8;
  logic         settled;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;

  switch_debouncer #(
    .N_SW(10),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .sw8(sw8),
    .settled(settled),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int           when;
    string        name;
    logic [N-1:0] clean;
    logic         st;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  typedef struct {
    int           when;
    logic [N-1:0] value;
  } chg_t;

  exp_t exp_q[$];
  chg_t chg_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_at(input int when, input string name, input logic [N-1:0] clean,
                           input logic st, input logic [N-1:0] rise = '0,
                           input logic [N-1:0] fall = '0);
    exp_t e;
    e.when  = when;
    e.name  = name;
    e.clean = clean;
    e.st    = st;
    e.rise  = EDGE ? rise : '0;
    e.fall  = EDGE ? fall : '0;
    exp_q.push_back(e);
  endtask

  task automatic expect_change(input int when, input logic [N-1:0] value);
    chg_t c;
    c.when  = when;
    c.value = value;
    chg_q.push_back(c);
  endtask

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: samples 2 time units after each falling edge.
  initial begin
    logic [N-1:0] prev;
    chg_t         c;
    prev = '0;
    forever begin
      @(negedge Clock);
      #2;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].when == cyc) begin
          cmp({exp_q[i].name, "/sw_clean"}, sw_clean, exp_q[i].clean);
          cmp({exp_q[i].name, "/sw8"}, {9'b0, sw8}, {9'b0, exp_q[i].clean[8]});
          cmp({exp_q[i].name, "/settled"}, {9'b0, settled}, {9'b0, exp_q[i].st});
          cmp({exp_q[i].name, "/sw_rise"}, sw_rise, exp_q[i].rise);
          cmp({exp_q[i].name, "/sw_fall"}, sw_fall, exp_q[i].fall);
          exp_q.delete(i);
        end else if (exp_q[i].when < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s overdue: got cycle %0d, expected cycle %0d", exp_q[i].name, cyc,
                   exp_q[i].when);
          exp_q.delete(i);
        end
      end
      if (sw_clean !== prev) begin
        if (chg_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change at cycle %0d: got %h, expected %h", cyc, sw_clean,
                   prev);
        end else begin
          c = chg_q.pop_front();
          cmp("change_value", sw_clean, c.value);
          n_checks++;
          if (c.when != cyc) begin
            n_fail++;
            $display("FAIL change_time: got cycle %0d, expected cycle %0d", cyc, c.when);
          end
        end
        prev = sw_clean;
      end else if (chg_q.size() > 0 && chg_q[0].when < cyc) begin
        c = chg_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_change: got %h at cycle %0d, expected %h at cycle %0d", sw_clean,
                 cyc, c.value, c.when);
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int k;
    int r;
    nReset = 1'b1;
    sw_raw = '0;
    #1 nReset = 1'b0;

    @(negedge Clock);
    expect_at(cyc, "reset", 10'h000, 1'b1);
    @(negedge Clock);
    nReset = 1'b1;
    expect_at(cyc, "reset_release", 10'h000, 1'b1);
    tick(2);

    // Clean step on bit 8.
    k = cyc;
    sw_raw[8] = 1'b1;
    expect_at(k + 2, "a_idle", 10'h000, 1'b1);
    expect_at(k + 3, "a_check", 10'h000, 1'b0);
    expect_at(k + 5, "a_not_yet", 10'h000, 1'b0);
    expect_at(k + 6, "a_accept", 10'h100, 1'b1, 10'h100, 10'h000);
    expect_at(k + 7, "a_after", 10'h100, 1'b1);
    expect_change(k + 6, 10'h100);
    tick(8);

    // Release bit 8.
    k = cyc;
    sw_raw[8] = 1'b0;
    expect_at(k + 5, "a2_hold", 10'h100, 1'b0);
    expect_at(k + 6, "a2_drop", 10'h000, 1'b1, 10'h000, 10'h100);
    expect_at(k + 7, "a2_after", 10'h000, 1'b1);
    expect_change(k + 6, 10'h000);
    tick(8);

    // Three-cycle glitch on bit 8 is rejected.
    k = cyc;
    sw_raw[8] = 1'b1;
    expect_at(k + 3, "b_check", 10'h000, 1'b0);
    expect_at(k + 5, "b_cnt3", 10'h000, 1'b0);
    expect_at(k + 6, "b_reject", 10'h000, 1'b1);
    expect_at(k + 8, "b_idle", 10'h000, 1'b1);
    tick(3);
    sw_raw[8] = 1'b0;
    tick(7);

    // Bit 3: 3 high, 1 low, 3 high; the dip restarts the count.
    k = cyc;
    sw_raw[3] = 1'b1;
    expect_at(k + 5, "r_cnt3", 10'h000, 1'b0);
    expect_at(k + 6, "r_restart", 10'h000, 1'b1);
    expect_at(k + 7, "r_recheck", 10'h000, 1'b0);
    expect_at(k + 9, "r_cnt3b", 10'h000, 1'b0);
    expect_at(k + 10, "r_reject", 10'h000, 1'b1);
    expect_at(k + 12, "r_idle", 10'h000, 1'b1);
    tick(3);
    sw_raw[3] = 1'b0;
    tick(1);
    sw_raw[3] = 1'b1;
    tick(3);
    sw_raw[3] = 1'b0;
    tick(6);

    // All bits high, reset during the 2nd CHECK cycle.
    k = cyc;
    sw_raw = '1;
    expect_at(k + 3, "c_check", 10'h000, 1'b0);
    tick(4);
    nReset = 1'b0;
    expect_at(cyc, "c_reset", 10'h000, 1'b1);
    tick(1);
    r = cyc;
    nReset = 1'b1;
    expect_at(r, "c_released", 10'h000, 1'b1);
    expect_at(r + 2, "c_idle", 10'h000, 1'b1);
    expect_at(r + 3, "c_check2", 10'h000, 1'b0);
    expect_at(r + 5, "c_not_yet", 10'h000, 1'b0);
    expect_at(r + 6, "c_accept", 10'h3FF, 1'b1, 10'h3FF, 10'h000);
    expect_at(r + 7, "c_after", 10'h3FF, 1'b1);
    expect_change(r + 6, 10'h3FF);
    tick(8);

    k = cyc;
    sw_raw = '0;
    expect_at(k + 6, "c2_drop", 10'h000, 1'b1, 10'h000, 10'h3FF);
    expect_at(k + 7, "c2_after", 10'h000, 1'b1);
    expect_change(k + 6, 10'h000);
    tick(8);

    // Bit 0 rises then falls 10 cycles later: one pulse each.
    k = cyc;
    sw_raw[0] = 1'b1;
    expect_at(k + 6, "d_rise", 10'h001, 1'b1, 10'h001, 10'h000);
    expect_at(k + 7, "d_rise_end", 10'h001, 1'b1);
    expect_at(k + 15, "d_hold", 10'h001, 1'b0);
    expect_at(k + 16, "d_fall", 10'h000, 1'b1, 10'h000, 10'h001);
    expect_at(k + 17, "d_fall_end", 10'h000, 1'b1);
    expect_change(k + 6, 10'h001);
    expect_change(k + 16, 10'h000);
    tick(10);
    sw_raw[0] = 1'b0;
    tick(9);

    // Bits 0 and 9 change two cycles apart.
    k = cyc;
    sw_raw[0] = 1'b1;
    expect_at(k + 5, "e_b0_wait", 10'h000, 1'b0);
    expect_at(k + 6, "e_b0", 10'h001, 1'b0, 10'h001, 10'h000);
    expect_at(k + 7, "e_b9_wait", 10'h001, 1'b0);
    expect_at(k + 8, "e_b9", 10'h201, 1'b1, 10'h200, 10'h000);
    expect_at(k + 9, "e_after", 10'h201, 1'b1);
    expect_change(k + 6, 10'h001);
    expect_change(k + 8, 10'h201);
    tick(2);
    sw_raw[9] = 1'b1;
    tick(10);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: got %0d, expected 0", exp_q.size());
    end
    n_checks++;
    if (chg_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_changes: got %0d, expected 0", chg_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
